// File: rtl/password_lock_ctrl.sv
// Keypad password lock: BCD entry/edit, password check with retry lockout,
// password change mode and a three-tone square-wave buzzer.
module password_lock_ctrl #(
    parameter int                  DIGITS     = 3,
    parameter int                  MAX_TRIES  = 3,
    parameter int                  LOCK_SECS  = 20,
    parameter int                  SEC_CYCLES = 50_000_000,
    parameter logic [4*DIGITS-1:0] INIT_CODE  = (4*DIGITS)'(12'h246),
    parameter int                  HP_KEY     = 50000,
    parameter int                  HP_OK      = 25000,
    parameter int                  HP_FAIL    = 100000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [15:0]                  onehot,
    output logic [4*DIGITS-1:0]          binary,
    output logic [$clog2(DIGITS+1)-1:0]  times,
    output logic [3:0]                   tries,
    output logic [1:0]                   mode,
    output logic                         buzzer
);

    localparam int W        = 4*DIGITS;
    localparam int TW       = $clog2(DIGITS+1);
    localparam int SW       = $clog2(SEC_CYCLES+1);
    localparam int KEY_LEN  = SEC_CYCLES/5;
    localparam int OK_LEN   = 3*SEC_CYCLES/5;
    localparam int FSEG     = SEC_CYCLES/10;
    localparam int FAIL_LEN = 3*FSEG;
    localparam int DW       = $clog2(OK_LEN+1);
    localparam int HP_MAX   = (HP_FAIL > HP_KEY) ? ((HP_FAIL > HP_OK) ? HP_FAIL : HP_OK)
                                                 : ((HP_KEY > HP_OK) ? HP_KEY : HP_OK);
    localparam int HW       = $clog2(HP_MAX+1);

    localparam logic [W-1:0] ALL_F    = {DIGITS{4'hF}};
    localparam logic [W-1:0] ALL_D    = {DIGITS{4'hD}};
    localparam logic [7:0]   LOCK_BCD = 8'((LOCK_SECS/10)*16 + LOCK_SECS%10);

    localparam logic [3:0] K_ENTER = 4'd10;
    localparam logic [3:0] K_SET   = 4'd11;
    localparam logic [3:0] K_CLEAR = 4'd12;
    localparam logic [3:0] K_BACK  = 4'd13;

    // "PASS" rendered as A,B,C,C, left-aligned; longer displays are padded with A on the left.
    function automatic logic [W-1:0] pass_pat();
        logic [W-1:0] p;
        int           k;
        p = '0;
        for (int i = 0; i < DIGITS; i++) begin
            k = i - ((DIGITS > 4) ? DIGITS-4 : 0);
            p[4*(DIGITS-1-i) +: 4] = (k <= 0) ? 4'hA : (k == 1) ? 4'hB : 4'hC;
        end
        return p;
    endfunction

    localparam logic [W-1:0] PASS_PAT = pass_pat();

    typedef enum logic [1:0] {M_ENTRY = 2'b00, M_SET = 2'b01, M_PASS = 2'b10, M_LOCK = 2'b11} mode_e;
    // Encoding order doubles as priority order.
    typedef enum logic [1:0] {S_NONE = 2'd0, S_KEY = 2'd1, S_OK = 2'd2, S_FAIL = 2'd3} snd_e;

    mode_e           mode_q, mode_d;
    logic [W-1:0]    bin_q, bin_d;
    logic [W-1:0]    secret_q, secret_d;
    logic [TW-1:0]   times_q, times_d;
    logic [3:0]      tries_q, tries_d;
    logic [7:0]      cd_q, cd_d;
    logic [SW-1:0]   sec_q, sec_d;
    logic [15:0]     prev_q, prev_d;
    logic            armed_q, armed_d;
    logic            key_vld_q, key_vld_d;
    logic [3:0]      key_q, key_d;
    snd_e            snd_q, snd_d, snd_req;
    logic [DW-1:0]   dur_q, dur_d, snd_last;
    logic [HW-1:0]   hp_q, hp_d, hp_last;
    logic            buzz_q, buzz_d;

    logic            dec_ok;
    logic [3:0]      dec_code;

    always_comb begin
        dec_ok   = 1'b1;
        dec_code = 4'd0;
        case (onehot)
            16'h0008: dec_code = 4'd0;
            16'h0080: dec_code = 4'd1;
            16'h0040: dec_code = 4'd2;
            16'h0020: dec_code = 4'd3;
            16'h0800: dec_code = 4'd4;
            16'h0400: dec_code = 4'd5;
            16'h0200: dec_code = 4'd6;
            16'h8000: dec_code = 4'd7;
            16'h4000: dec_code = 4'd8;
            16'h2000: dec_code = 4'd9;
            16'h0001: dec_code = K_ENTER;
            16'h0010: dec_code = K_SET;
            16'h0100: dec_code = K_CLEAR;
            16'h1000: dec_code = K_BACK;
            default:  dec_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= M_ENTRY;
            bin_q     <= ALL_F;
            secret_q  <= INIT_CODE;
            times_q   <= '0;
            tries_q   <= '0;
            cd_q      <= '0;
            sec_q     <= '0;
            prev_q    <= '0;
            armed_q   <= 1'b0;
            key_vld_q <= 1'b0;
            key_q     <= '0;
            snd_q     <= S_NONE;
            dur_q     <= '0;
            hp_q      <= '0;
            buzz_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            bin_q     <= bin_d;
            secret_q  <= secret_d;
            times_q   <= times_d;
            tries_q   <= tries_d;
            cd_q      <= cd_d;
            sec_q     <= sec_d;
            prev_q    <= prev_d;
            armed_q   <= armed_d;
            key_vld_q <= key_vld_d;
            key_q     <= key_d;
            snd_q     <= snd_d;
            dur_q     <= dur_d;
            hp_q      <= hp_d;
            buzz_q    <= buzz_d;
        end
    end

    always_comb begin
        snd_last = '0;
        hp_last  = '0;
        case (snd_q)
            S_KEY:   begin snd_last = DW'(KEY_LEN-1);  hp_last = HW'(HP_KEY-1);  end
            S_OK:    begin snd_last = DW'(OK_LEN-1);   hp_last = HW'(HP_OK-1);   end
            S_FAIL:  begin snd_last = DW'(FAIL_LEN-1); hp_last = HW'(HP_FAIL-1); end
            default: ;
        endcase
    end

    always_comb begin
        mode_d    = mode_q;
        bin_d     = bin_q;
        secret_d  = secret_q;
        times_d   = times_q;
        tries_d   = tries_q;
        cd_d      = cd_q;
        sec_d     = sec_q;
        snd_req   = S_NONE;
        // armed_q clears on reset so a key held through reset needs a fresh release first.
        prev_d    = onehot;
        armed_d   = (onehot == 16'h0000);
        key_vld_d = armed_q && (prev_q == 16'h0000) && dec_ok;
        key_d     = dec_code;

        if (mode_q == M_LOCK) begin
            if (sec_q == SW'(SEC_CYCLES-1)) begin
                sec_d = '0;
                if (cd_q == 8'h00) begin
                    mode_d  = M_ENTRY;
                    bin_d   = ALL_F;
                    times_d = '0;
                end else begin
                    cd_d       = (cd_q[3:0] == 4'd0) ? {cd_q[7:4] - 4'd1, 4'd9}
                                                     : {cd_q[7:4], cd_q[3:0] - 4'd1};
                    bin_d      = ALL_F;
                    bin_d[7:0] = cd_d;
                end
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end else if (key_vld_q) begin
            case (key_q)
                K_ENTER: begin
                    if (times_q == TW'(DIGITS) && mode_q == M_ENTRY) begin
                        if (bin_q == secret_q) begin
                            mode_d  = M_PASS;
                            bin_d   = PASS_PAT;
                            tries_d = '0;
                            snd_req = S_OK;
                        end else if (tries_q == 4'(MAX_TRIES-1)) begin
                            mode_d     = M_LOCK;
                            cd_d       = LOCK_BCD;
                            sec_d      = '0;
                            tries_d    = '0;
                            times_d    = '0;
                            bin_d      = ALL_F;
                            bin_d[7:0] = LOCK_BCD;
                            snd_req    = S_FAIL;
                        end else begin
                            tries_d = tries_q + 4'd1;
                            times_d = '0;
                            bin_d   = ALL_F;
                            snd_req = S_FAIL;
                        end
                    end else if (times_q == TW'(DIGITS) && mode_q == M_SET) begin
                        secret_d = bin_q;
                        mode_d   = M_ENTRY;
                        bin_d    = ALL_F;
                        times_d  = '0;
                        tries_d  = '0;
                        snd_req  = S_OK;
                    end
                end
                K_SET: begin
                    if (mode_q == M_ENTRY || mode_q == M_PASS) begin
                        mode_d  = M_SET;
                        bin_d   = ALL_D;
                        times_d = '0;
                        snd_req = S_KEY;
                    end
                end
                K_CLEAR: begin
                    mode_d  = M_ENTRY;
                    bin_d   = ALL_F;
                    times_d = '0;
                    tries_d = '0;
                    snd_req = S_KEY;
                end
                K_BACK: begin
                    if ((mode_q == M_ENTRY || mode_q == M_SET) && times_q != '0) begin
                        bin_d   = {(mode_q == M_SET) ? 4'hD : 4'hF, bin_q[W-1:4]};
                        times_d = times_q - 1'b1;
                        snd_req = S_KEY;
                    end
                end
                default: begin
                    if ((mode_q == M_ENTRY || mode_q == M_SET) && times_q < TW'(DIGITS)) begin
                        bin_d   = {bin_q[W-5:0], key_q};
                        times_d = times_q + 1'b1;
                        snd_req = S_KEY;
                    end
                end
            endcase
        end

        snd_d  = snd_q;
        dur_d  = dur_q;
        hp_d   = hp_q;
        buzz_d = buzz_q;
        if (snd_req != S_NONE && snd_req >= snd_q) begin
            snd_d  = snd_req;
            dur_d  = '0;
            hp_d   = '0;
            buzz_d = 1'b0;
        end else if (snd_q != S_NONE) begin
            if (dur_q == snd_last) begin
                snd_d  = S_NONE;
                dur_d  = '0;
                hp_d   = '0;
                buzz_d = 1'b0;
            end else begin
                dur_d = dur_q + 1'b1;
                if (hp_q == hp_last) begin
                    hp_d   = '0;
                    buzz_d = ~buzz_q;
                end else begin
                    hp_d = hp_q + 1'b1;
                end
            end
        end
    end

    // The FAIL tone keeps its phase running through the silent middle segment.
    always_comb begin
        binary = bin_q;
        times  = times_q;
        tries  = tries_q;
        mode   = mode_q;
        buzzer = buzz_q && !(snd_q == S_FAIL && dur_q >= DW'(FSEG) && dur_q < DW'(2*FSEG));
    end

endmodule

// File: tb/tb_password_lock_ctrl.sv
// Directed bench for password_lock_ctrl: 3-digit instance plus a 4-digit instance
// sharing keypad and reset, with short second and tone periods.
module tb_password_lock_ctrl;

    localparam logic [15:0] K1 = 16'h0080, K2 = 16'h0040, K3 = 16'h0020, K4 = 16'h0800;
    localparam logic [15:0] K5 = 16'h0400, K6 = 16'h0200, K7 = 16'h8000, K8 = 16'h4000;
    localparam logic [15:0] K9 = 16'h2000, KENT = 16'h0001, KSET = 16'h0010;
    localparam logic [15:0] KCLR = 16'h0100, KBCK = 16'h1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] onehot;
    logic [11:0] binary;
    logic [1:0]  times;
    logic [3:0]  tries;
    logic [1:0]  mode;
    logic        buzzer;
    logic [15:0] bin2;
    logic [2:0]  times2;
    logic [3:0]  tries2;
    logic [1:0]  mode2;
    logic        buz2;

    int nerr = 0;
    int nchk = 0;
    int cyc = 0;
    int rises = 0;
    int r0, n, lock_cyc;

    password_lock_ctrl #(.SEC_CYCLES(100), .HP_KEY(3), .HP_OK(4), .HP_FAIL(5)) dut (
        .clk(clk), .rst_n(rst_n), .onehot(onehot), .binary(binary),
        .times(times), .tries(tries), .mode(mode), .buzzer(buzzer));

    password_lock_ctrl #(.DIGITS(4), .INIT_CODE(16'h1357), .SEC_CYCLES(100),
                         .HP_KEY(3), .HP_OK(4), .HP_FAIL(5)) dut4 (
        .clk(clk), .rst_n(rst_n), .onehot(onehot), .binary(bin2),
        .times(times2), .tries(tries2), .mode(mode2), .buzzer(buz2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge buzzer) rises <= rises + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Action lands on the 2nd rising edge after the key appears; returns 4 edges after that.
    task automatic press(input logic [15:0] code);
        @(negedge clk) onehot = code;
        repeat (3) @(negedge clk);
        onehot = 16'h0000;
        repeat (3) @(negedge clk);
    endtask

    function automatic logic bsel(input bit sel);
        return sel ? buz2 : buzzer;
    endfunction

    // Length in cycles of the next complete high phase of the chosen buzzer, -1 on timeout.
    task automatic measure_hp(input bit sel, output int hp);
        int k;
        k  = 0;
        hp = -1;
        while (bsel(sel) !== 1'b0 && k < 300) begin @(negedge clk); k++; end
        while (bsel(sel) !== 1'b1 && k < 300) begin @(negedge clk); k++; end
        if (k >= 300) return;
        hp = 0;
        while (bsel(sel) === 1'b1 && hp < 300) begin @(negedge clk); hp++; end
    endtask

    initial begin
        rst_n  = 1'b0;
        onehot = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_binary", binary, 12'hFFF);
        chk("rst_times", times, 2'd0);
        chk("rst_tries", tries, 4'd0);
        chk("rst_mode", mode, 2'b00);
        chk("rst_buzzer", buzzer, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // correct default password
        r0 = rises;
        press(K2);
        chk("e1_bin", binary, 12'hFF2);
        chk("e1_times", times, 2'd1);
        chk("e1_beep", rises > r0, 1'b1);
        press(K4);
        chk("e2_bin", binary, 12'hF24);
        press(K6);
        chk("e3_bin", binary, 12'h246);
        chk("e3_times", times, 2'd3);
        press(KENT);
        chk("pass_mode", mode, 2'b10);
        chk("pass_bin", binary, 12'hABC);
        chk("pass_tries", tries, 4'd0);
        measure_hp(1'b0, n);
        chk("ok_halfper", n, 4);
        repeat (70) @(negedge clk);
        chk("ok_silent", buzzer, 1'b0);

        press(KCLR);
        chk("clr_mode", mode, 2'b00);
        chk("clr_bin", binary, 12'hFFF);
        chk("clr_times", times, 2'd0);

        // ENTER with a short entry is ignored
        press(K1);
        press(KENT);
        chk("short_ent_mode", mode, 2'b00);
        chk("short_ent_bin", binary, 12'hFF1);
        chk("short_ent_tries", tries, 4'd0);
        press(KCLR);

        // three wrong entries -> lockout
        press(K1); press(K1); press(K1); press(KENT);
        chk("w1_tries", tries, 4'd1);
        chk("w1_bin", binary, 12'hFFF);
        chk("w1_times", times, 2'd0);
        chk("w1_mode", mode, 2'b00);
        measure_hp(1'b0, n);
        chk("fail_halfper", n, 5);
        press(K1); press(K1); press(K1); press(KENT);
        chk("w2_tries", tries, 4'd2);
        press(K1); press(K1); press(K1); press(KENT);
        lock_cyc = cyc - 4;
        chk("lock_mode", mode, 2'b11);
        chk("lock_bin", binary, 12'hF20);
        chk("lock_tries", tries, 4'd0);
        press(K5);
        chk("lock_key_bin", binary, 12'hF20);
        chk("lock_key_mode", mode, 2'b11);
        while (cyc - lock_cyc < 150) @(negedge clk);
        chk("lock_19", binary, 12'hF19);
        while (cyc - lock_cyc < 1050) @(negedge clk);
        chk("lock_10", binary, 12'hF10);
        n = 0;
        while (binary !== 12'hF00 && n < 3000) begin @(negedge clk); n++; end
        chk("lock_00_at", cyc - lock_cyc, 2000);
        chk("lock_00_mode", mode, 2'b11);
        n = 0;
        while (mode !== 2'b00 && n < 3000) begin @(negedge clk); n++; end
        chk("unlock_at", cyc - lock_cyc, 2100);
        chk("unlock_bin", binary, 12'hFFF);

        // change password to 789
        press(KSET);
        chk("set_mode", mode, 2'b01);
        chk("set_bin", binary, 12'hDDD);
        chk("set_times", times, 2'd0);
        press(K7);
        chk("set_d1", binary, 12'hDD7);
        press(K8); press(K9);
        chk("set_d3", binary, 12'h789);
        press(KENT);
        chk("set_done_mode", mode, 2'b00);
        chk("set_done_bin", binary, 12'hFFF);
        press(K7); press(K8); press(K9); press(KENT);
        chk("new_pass_mode", mode, 2'b10);
        chk("new_pass_bin", binary, 12'hABC);
        press(KSET);
        chk("set_from_pass", mode, 2'b01);
        press(KCLR);
        chk("clr_from_set", mode, 2'b00);
        chk("clr_from_set_bin", binary, 12'hFFF);
        press(K2); press(K4); press(K6); press(KENT);
        chk("old_pw_mode", mode, 2'b00);
        chk("old_pw_tries", tries, 4'd1);

        // BACK editing
        press(KCLR);
        chk("clr_tries", tries, 4'd0);
        press(K1); press(K2); press(KBCK);
        chk("back_bin", binary, 12'hFF1);
        chk("back_times", times, 2'd1);
        press(K3);
        chk("back_k3_bin", binary, 12'hF13);
        chk("back_k3_times", times, 2'd2);
        press(KBCK); press(KBCK);
        chk("back_empty", binary, 12'hFFF);
        repeat (40) @(negedge clk);
        r0 = rises;
        press(KBCK);
        repeat (20) @(negedge clk);
        chk("back0_bin", binary, 12'hFFF);
        chk("back0_times", times, 2'd0);
        chk("back0_nobeep", rises, r0);

        // digit beyond DIGITS ignored silently
        press(K1); press(K2); press(K3);
        repeat (40) @(negedge clk);
        r0 = rises;
        press(K4);
        repeat (20) @(negedge clk);
        chk("full_bin", binary, 12'h123);
        chk("full_times", times, 2'd3);
        chk("full_nobeep", rises, r0);

        // multi-hot, changing held code, unmapped code
        press(KCLR);
        repeat (40) @(negedge clk);
        r0 = rises;
        @(negedge clk) onehot = 16'h0028;
        repeat (3) @(negedge clk);
        onehot = 16'h0008;
        repeat (3) @(negedge clk);
        onehot = 16'h0000;
        press(16'h0002);
        repeat (20) @(negedge clk);
        chk("multi_bin", binary, 12'hFFF);
        chk("multi_times", times, 2'd0);
        chk("multi_nobeep", rises, r0);
        @(negedge clk) onehot = K5;
        repeat (12) @(negedge clk);
        onehot = 16'h0000;
        repeat (3) @(negedge clk);
        chk("held_bin", binary, 12'hFF5);
        chk("held_times", times, 2'd1);

        // reset in the middle of LOCK, with a key held across it
        press(KCLR);
        for (int w = 0; w < 3; w++) begin
            press(K1); press(K1); press(K1); press(KENT);
        end
        chk("lock2_mode", mode, 2'b11);
        repeat (3) @(negedge clk);
        onehot = K1;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_bin", binary, 12'hFFF);
        chk("mid_rst_mode", mode, 2'b00);
        chk("mid_rst_buzzer", buzzer, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("held_rst_bin", binary, 12'hFFF);
        chk("held_rst_times", times, 2'd0);
        onehot = 16'h0000;
        repeat (2) @(negedge clk);
        press(K2); press(K4); press(K6);
        chk("after_rst_bin", binary, 12'h246);
        press(KENT);
        chk("secret_restored", mode, 2'b10);

        // 4-digit instance
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        press(K1); press(K3); press(K5); press(K7);
        chk("d4_bin", bin2, 16'h1357);
        chk("d4_times", times2, 3'd4);
        press(KENT);
        chk("d4_mode", mode2, 2'b10);
        chk("d4_pass_bin", bin2, 16'hABCC);
        chk("d4_tries", tries2, 4'd0);
        measure_hp(1'b1, n);
        chk("d4_ok_halfper", n, 4);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
